memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results through, performs aligned byte/half/word
// data-memory accesses with a held request, and optionally bounds the wait with a timeout.
module memory_stage #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_load_regfile,
  input  logic        stall_in,
  output logic        stall_out,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        out_valid,
  output logic        out_load_regfile,
  output logic        out_misaligned,
  output logic        out_timeout,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [1:0]  state;
  logic [31:0] wait_cnt;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        req_load, req_lrf;
  logic [31:0] hold_data;
  logic        hold_lrf, hold_timeout;

  logic        is_mem, misaligned, timeout_hit, complete;
  logic [3:0]  st_mask;
  logic [31:0] st_data, ld_shift, ld_data, cmp_data;
  logic        cmp_lrf, cmp_timeout;

  // Handshake: stall_in=1 means downstream will not take the output register this
  // cycle; stall_out=1 means the upstream stage must keep its instruction unchanged.
  assign stall_out = stall_in | (state != IDLE);
  assign state_dbg = state;

  assign is_mem     = in_load | in_store;
  assign misaligned = is_mem && (((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                                 ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));

  always_comb begin
    st_mask = 4'b1111;
    st_data = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin st_mask = 4'b0001 << in_addr[1:0]; st_data = {4{in_wdata[7:0]}}; end
      2'b01: begin st_mask = 4'b0011 << in_addr[1:0]; st_data = {2{in_wdata[15:0]}}; end
      default: ;
    endcase
  end

  assign ld_shift = dmem_rdata >> {req_addr[1:0], 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (req_funct3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // A response arriving on the timeout cycle still wins over the timeout.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == TO_LAST);
  assign complete    = (state == ACCESS) && (dmem_resp || timeout_hit);
  assign cmp_timeout = !dmem_resp;
  assign cmp_lrf     = dmem_resp ? req_lrf : 1'b0;
  assign cmp_data    = dmem_resp ? (req_load ? ld_data : req_addr) : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;  wait_cnt <= '0;
      req_addr <= '0; req_funct3 <= '0; req_rd <= '0; req_load <= 1'b0; req_lrf <= 1'b0;
      hold_data <= '0; hold_lrf <= 1'b0; hold_timeout <= 1'b0;
      dmem_read <= 1'b0; dmem_write <= 1'b0; dmem_addr <= '0; dmem_wmask <= '0; dmem_wdata <= '0;
      out_valid <= 1'b0; out_load_regfile <= 1'b0; out_misaligned <= 1'b0;
      out_timeout <= 1'b0; out_rd <= '0; out_data <= '0;
    end else begin
      case (state)
        IDLE: if (!stall_in) begin
          if (in_valid && is_mem && !misaligned) begin
            state      <= ACCESS;
            wait_cnt   <= '0;
            req_addr   <= in_addr;
            req_funct3 <= in_funct3;
            req_rd     <= in_rd;
            req_load   <= in_load;
            req_lrf    <= in_load_regfile;
            dmem_read  <= in_load;
            dmem_write <= in_store;
            dmem_addr  <= {in_addr[31:2], 2'b00};
            dmem_wmask <= in_store ? st_mask : 4'b0000;
            dmem_wdata <= in_store ? st_data : 32'd0;
            out_valid  <= 1'b0;
          end else begin
            out_valid        <= in_valid;
            out_data         <= in_addr;
            out_rd           <= in_rd;
            out_load_regfile <= in_load_regfile & ~misaligned;
            out_misaligned   <= in_valid & misaligned;
            out_timeout      <= 1'b0;
          end
        end
        ACCESS: begin
          if (complete) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (stall_in) begin
              state        <= HOLD;
              hold_data    <= cmp_data;
              hold_lrf     <= cmp_lrf;
              hold_timeout <= cmp_timeout;
            end else begin
              state            <= IDLE;
              out_valid        <= 1'b1;
              out_data         <= cmp_data;
              out_rd           <= req_rd;
              out_load_regfile <= cmp_lrf;
              out_misaligned   <= 1'b0;
              out_timeout      <= cmp_timeout;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        HOLD: if (!stall_in) begin
          state            <= IDLE;
          out_valid        <= 1'b1;
          out_data         <= hold_data;
          out_rd           <= req_rd;
          out_load_regfile <= hold_lrf;
          out_misaligned   <= 1'b0;
          out_timeout      <= hold_timeout;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
